pe_cmd_dispatcher: RTL and testbench

- Upstream command stage for the PE core.
- Buffers incoming 32-bit PE instructions in a FIFO and issues them one at a time as a single-cycle start pulse plus a stable instruction word.
- Waits for the core's done pulse before issuing the next command. Enforces a completion timeout, drops illegal opcodes, and reports status to the host controller.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_cmd_fifo.sv | 63 ++++++
 rtl/pe_cmd_dispatcher.sv | 113 +++++++++++
 tb/tb_pe_cmd_dispatcher.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared opcode encodings, dispatcher state type and opcode classification
// for the PE command path.
package pe_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MAC  = 4'd1;
  localparam logic [3:0] OP_ACT  = 4'd2;
  localparam logic [3:0] OP_NORM = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } disp_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_MAC) || (op == OP_ACT) || (op == OP_NORM);
  endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry.
// Pushes into a full FIFO and pops from an empty one are ignored.
module pe_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == {CW{1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = wr_en && !full;
  assign pop_s  = rd_en && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pe_cmd_dispatcher.sv
// Command dispatcher: queues PE instructions and issues them one at a time,
// retiring NOPs locally, dropping illegal opcodes and timing out stuck commands.
module pe_cmd_dispatcher
  import pe_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [INSTR_WIDTH-1:0]   cmd_instr,
  output logic                     pe_start,
  output logic [INSTR_WIDTH-1:0]   pe_instr,
  input  logic                     pe_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]     retired_count,
  output logic                     err_timeout,
  output logic                     err_illegal,
  input  logic                     err_clear
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  disp_state_e            state_r;
  logic [TW-1:0]          timer_r;
  logic [INSTR_WIDTH-1:0] head_s;
  logic [3:0]             head_op_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   pop_s;

  assign head_op_s = head_s[INSTR_WIDTH-1 -: 4];
  assign pop_s     = (state_r == ST_IDLE) && !empty_s;
  assign cmd_ready = !full_s;
  assign busy      = (state_r != ST_IDLE) || !empty_s;

  pe_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (cmd_valid),
    .din   (cmd_instr),
    .rd_en (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  // Dispatch FSM; error sets are written after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TW{1'b0}};
      pe_start      <= 1'b0;
      pe_instr      <= {INSTR_WIDTH{1'b0}};
      retired_count <= {CNT_WIDTH{1'b0}};
      err_timeout   <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      pe_start <= 1'b0;
      if (err_clear) begin
        err_timeout <= 1'b0;
        err_illegal <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            if (is_legal_op(head_op_s)) begin
              pe_instr <= head_s;
              pe_start <= 1'b1;
              state_r  <= ST_ISSUE;
            end else if (head_op_s == OP_NOP) begin
              retired_count <= retired_count + CNT_WIDTH'(1);
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          timer_r <= {TW{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_done) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
            state_r       <= ST_IDLE;
          end else if (timer_r == TIMER_LAST) begin
            err_timeout <= 1'b1;
            state_r     <= ST_ERR;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_ERR: begin
          if (err_clear) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_cmd_dispatcher.sv
// Directed self-checking bench for pe_cmd_dispatcher (TIMEOUT_CYCLES=16).
module tb_pe_cmd_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_instr;
  logic        pe_start;
  logic [31:0] pe_instr;
  logic        pe_done;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] retired_count;
  logic        err_timeout;
  logic        err_illegal;
  logic        err_clear;

  int checks = 0;
  int errors = 0;

  pe_cmd_dispatcher #(
    .DEPTH          (8),
    .INSTR_WIDTH    (32),
    .TIMEOUT_CYCLES (16),
    .CNT_WIDTH      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_instr     (cmd_instr),
    .pe_start      (pe_start),
    .pe_instr      (pe_instr),
    .pe_done       (pe_done),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .retired_count (retired_count),
    .err_timeout   (err_timeout),
    .err_illegal   (err_illegal),
    .err_clear     (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int starts;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_instr = 32'h0; pe_done = 1'b0; err_clear = 1'b0;
    repeat (3) tick();
    chk("rst_start", pe_start, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_retired", retired_count, 0);
    chk("rst_errs", {err_timeout, err_illegal}, 0);
    chk("rst_instr", pe_instr, 0);

    // single command, done 3 cycles after start
    cmd_valid = 1'b1; cmd_instr = 32'h1000_0005;
    tick();
    cmd_valid = 1'b0;
    chk("t1_count", fifo_count, 1);
    chk("t1_nostart", pe_start, 0);
    tick();
    chk("t1_start", pe_start, 1);
    chk("t1_instr", pe_instr, 32'h1000_0005);
    tick();
    chk("t1_start_low", pe_start, 0);
    tick();
    tick();
    chk("t1_hold", pe_instr, 32'h1000_0005);
    chk("t1_busy", busy, 1);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("t1_retired", retired_count, 1);
    chk("t1_idle", busy, 0);

    // fill the FIFO behind a stalled command
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_instr = 32'h2000_0000 + i;
      tick();
    end
    chk("t2_count7", fifo_count, 7);
    chk("t2_inflight", pe_instr, 32'h2000_0000);
    cmd_instr = 32'h2000_0008;
    tick();
    chk("t2_count8", fifo_count, 8);
    chk("t2_full", cmd_ready, 0);
    cmd_instr = 32'h2000_00FF;
    tick();
    cmd_valid = 1'b0;
    chk("t2_refused", fifo_count, 8);
    for (int k = 1; k < 9; k++) begin
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      tick();
      chk("t2_gap_start", pe_start, 1);
      chk("t2_order", pe_instr, 32'h2000_0000 + k);
      tick();
    end
    chk("t2_drained", fifo_count, 0);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    tick();
    chk("t2_retired", retired_count, 10);
    chk("t2_idle", busy, 0);

    // two NOPs then a legal command
    cmd_valid = 1'b1; cmd_instr = 32'h0000_0000;
    tick();
    cmd_instr = 32'h0000_0001;
    tick();
    chk("t3_nop1", retired_count, 11);
    chk("t3_nop1_nostart", pe_start, 0);
    cmd_instr = 32'h3000_0002;
    tick();
    cmd_valid = 1'b0;
    chk("t3_nop2", retired_count, 12);
    chk("t3_nop2_nostart", pe_start, 0);
    tick();
    chk("t3_start", pe_start, 1);
    chk("t3_instr", pe_instr, 32'h3000_0002);
    tick();
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("t3_retired", retired_count, 13);

    // illegal opcode dropped, next command issues
    cmd_valid = 1'b1; cmd_instr = 32'hF000_0000;
    tick();
    cmd_instr = 32'h1000_0001;
    tick();
    cmd_valid = 1'b0;
    chk("t4_illegal", err_illegal, 1);
    chk("t4_nostart", pe_start, 0);
    chk("t4_noretire", retired_count, 13);
    tick();
    chk("t4_start", pe_start, 1);
    chk("t4_instr", pe_instr, 32'h1000_0001);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_cleared", err_illegal, 0);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("t4_retired", retired_count, 14);

    // set beats clear in the same cycle
    cmd_valid = 1'b1; cmd_instr = 32'h5000_0000;
    tick();
    cmd_valid = 1'b0;
    err_clear = 1'b1;
    tick();
    chk("t4_set_wins", err_illegal, 1);
    tick();
    err_clear = 1'b0;
    chk("t4_clear2", err_illegal, 0);

    // timeout with a queued command
    cmd_valid = 1'b1; cmd_instr = 32'h1000_0000;
    tick();
    cmd_instr = 32'h2000_0099;
    tick();
    cmd_valid = 1'b0;
    chk("t5_start", pe_start, 1);
    tick();
    repeat (15) tick();
    chk("t5_pre_timeout", err_timeout, 0);
    tick();
    chk("t5_timeout", err_timeout, 1);
    chk("t5_busy", busy, 1);
    repeat (3) tick();
    chk("t5_err_nostart", pe_start, 0);
    chk("t5_queued", fifo_count, 1);
    chk("t5_noretire", retired_count, 14);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t5_cleared", err_timeout, 0);
    tick();
    chk("t5_resume", pe_start, 1);
    chk("t5_resume_instr", pe_instr, 32'h2000_0099);
    tick();
    repeat (15) tick();
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("t5_done_wins", err_timeout, 0);
    chk("t5_retired", retired_count, 15);
    tick();
    chk("t5_idle", busy, 0);

    // reset in the middle of WAIT with three queued commands
    cmd_valid = 1'b1; cmd_instr = 32'h1000_0077;
    tick();
    for (int i = 1; i < 4; i++) begin
      cmd_instr = 32'h2000_0000 + i;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6_queued", fifo_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", fifo_count, 0);
    chk("t6_async_retired", retired_count, 0);
    chk("t6_async_instr", pe_instr, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pe_start) starts++;
    end
    chk("t6_no_start", starts, 0);
    chk("t6_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
